// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access lengths, MMIO offsets,
// fault bit indices and the address-decode record.
package dmem_pkg;

    typedef enum logic [1:0] {
        LEN_NONE = 2'b00,
        LEN_BYTE = 2'b01,
        LEN_HALF = 2'b10,
        LEN_WORD = 2'b11
    } len_e;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_FAULT  = 4'h8;
    localparam logic [3:0] OFF_MTIME  = 4'hC;

    localparam int FAULT_ALIGN    = 0;
    localparam int FAULT_RANGE    = 1;
    localparam int FAULT_OVERFLOW = 2;
    localparam int FAULT_BITS     = 3;

    typedef struct packed {
        logic ram;
        logic mmio;
        logic misalign;
        logic unmapped;
    } dec_t;

    // Natural alignment: halves on even lanes, words on lane 0.
    function automatic logic lane_ok(len_e len, logic [1:0] lane);
        case (len)
            LEN_HALF: lane_ok = !lane[0];
            LEN_WORD: lane_ok = (lane == 2'b00);
            default:  lane_ok = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU data-memory bus: store port, load port and combinational load result.
interface dmem_if;
    logic [1:0]  MEM_write_length;
    logic [31:0] MEM_write_address;
    logic [31:0] MEM_write_data;
    logic [1:0]  MEM_read_length;
    logic        MEM_read_signed;
    logic [31:0] MEM_read_address;
    logic [31:0] MEM_read_data;

    modport master (
        output MEM_write_length, MEM_write_address, MEM_write_data,
        output MEM_read_length, MEM_read_signed, MEM_read_address,
        input  MEM_read_data
    );

    modport slave (
        input  MEM_write_length, MEM_write_address, MEM_write_data,
        input  MEM_read_length, MEM_read_signed, MEM_read_address,
        output MEM_read_data
    );
endinterface

// File: rtl/dmem_tx_fifo.sv
// Synchronous byte FIFO for the console TX stream; flags a push lost to a full queue.
module dmem_tx_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          SYS_clk,
    input  logic          SYS_reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop_ready,
    output logic [7:0]    head,
    output logic          valid,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          drop
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign valid   = !empty;
    assign head    = empty ? 8'h00 : mem[rd_ptr];
    assign pop     = pop_ready && !empty;
    // A pop in the same cycle frees the head slot, so a push into a full queue still lands.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset && push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Data RAM plus MMIO window (console TX FIFO, sticky faults) on the CPU data bus.
// Optional free-running cycle counter at +0xC when DMEM_MTIME_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS     = 1024,
    parameter int          TX_FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE     = 32'h1000_0000
) (
    input  logic       SYS_clk,
    input  logic       SYS_reset,
    dmem_if.slave      mem,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       MEM_fault
);
    localparam int          AW        = $clog2(RAM_WORDS);
    localparam int          CW        = $clog2(TX_FIFO_DEPTH) + 1;
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    function automatic dec_t decode(logic [31:0] a, len_e len);
        dec_t d;
        d.ram  = ({1'b0, a} < RAM_BYTES);
        d.mmio = (a[31:4] == MMIO_BASE[31:4]);
`ifndef DMEM_MTIME_EN
        if (a[3:2] == OFF_MTIME[3:2]) d.mmio = 1'b0;
`endif
        d.unmapped = !d.ram && !d.mmio;
        if (d.ram)       d.misalign = !lane_ok(len, a[1:0]);
        else if (d.mmio) d.misalign = (len != LEN_WORD) || (a[1:0] != 2'b00);
        else             d.misalign = 1'b0;
        return d;
    endfunction

    logic [31:0]           ram [RAM_WORDS];
    len_e                  wlen, rlen;
    dec_t                  wd, rd;
    logic                  wr_act, w_ram, w_mmio;
    logic [3:0]            wbe;
    logic [31:0]           wdat, rword, rsh, rdata;
    logic [FAULT_BITS-1:0] fault, fset, fclr;
    logic                  fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0]         fifo_count;

    assign wlen   = len_e'(mem.MEM_write_length);
    assign rlen   = (mem.MEM_read_length == LEN_NONE) ? LEN_WORD : len_e'(mem.MEM_read_length);
    assign wd     = decode(mem.MEM_write_address, wlen);
    assign rd     = decode(mem.MEM_read_address, rlen);
    assign wr_act = (wlen != LEN_NONE);
    assign w_mmio = wr_act && wd.mmio && !wd.misalign;
    assign w_ram  = wr_act && wd.ram && !wd.misalign && !SYS_reset;

    always_comb begin
        wbe  = '0;
        wdat = mem.MEM_write_data;
        case (wlen)
            LEN_BYTE: begin
                wbe  = 4'b0001 << mem.MEM_write_address[1:0];
                wdat = {4{mem.MEM_write_data[7:0]}};
            end
            LEN_HALF: begin
                wbe  = 4'b0011 << mem.MEM_write_address[1:0];
                wdat = {2{mem.MEM_write_data[15:0]}};
            end
            LEN_WORD: wbe = 4'b1111;
            default:  wbe = '0;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (w_ram)
            for (int b = 0; b < 4; b++)
                if (wbe[b]) ram[mem.MEM_write_address[AW+1:2]][8*b +: 8] <= wdat[8*b +: 8];
    end

`ifdef DMEM_MTIME_EN
    logic [31:0] mtime;
    always_ff @(posedge SYS_clk) begin
        if (SYS_reset)                                                mtime <= '0;
        else if (w_mmio && mem.MEM_write_address[3:0] == OFF_MTIME)   mtime <= mem.MEM_write_data;
        else                                                          mtime <= mtime + 32'd1;
    end
`endif

    // Loads are side-effect free apart from recording faults; store to the same word is seen next cycle.
    always_comb begin
        rword = ram[mem.MEM_read_address[AW+1:2]];
        rsh   = rword >> {mem.MEM_read_address[1:0], 3'b000};
        rdata = '0;
        if (rd.ram && !rd.misalign) begin
            case (rlen)
                LEN_BYTE: rdata = {{24{mem.MEM_read_signed & rsh[7]}}, rsh[7:0]};
                LEN_HALF: rdata = {{16{mem.MEM_read_signed & rsh[15]}}, rsh[15:0]};
                default:  rdata = rword;
            endcase
        end else if (rd.mmio && !rd.misalign) begin
            case (mem.MEM_read_address[3:0])
                OFF_STATUS: rdata = {16'h0, 8'(fifo_count), 6'b0, fifo_empty, fifo_full};
                OFF_FAULT:  rdata = {{(32-FAULT_BITS){1'b0}}, fault};
`ifdef DMEM_MTIME_EN
                OFF_MTIME:  rdata = mtime;
`endif
                default:    rdata = '0;
            endcase
        end
    end
    assign mem.MEM_read_data = rdata;

    dmem_tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_fifo (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .push      (w_mmio && mem.MEM_write_address[3:0] == OFF_TXDATA),
        .push_data (mem.MEM_write_data[7:0]),
        .pop_ready (tx_ready),
        .head      (tx_data),
        .valid     (tx_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    // New faults in a cycle override a simultaneous write-1-to-clear of the same bit.
    always_comb begin
        fset                 = '0;
        fset[FAULT_ALIGN]    = (wr_act && wd.misalign) || rd.misalign;
        fset[FAULT_RANGE]    = (wr_act && wd.unmapped) || rd.unmapped;
        fset[FAULT_OVERFLOW] = fifo_drop;
        fclr = (w_mmio && mem.MEM_write_address[3:0] == OFF_FAULT) ?
               mem.MEM_write_data[FAULT_BITS-1:0] : '0;
    end

    always_ff @(posedge SYS_clk) begin
        if (SYS_reset) fault <= '0;
        else           fault <= (fault & ~fclr) | fset;
    end

    assign MEM_fault = |fault;
endmodule
